// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer and the tone generator that
// consumes its note codes.
package note_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2
  } seq_state_e;

  // Note code that means "silence" inside a recorded take.
  localparam int unsigned DEF_REST_CODE = 20000;
  // Note code presented to the tone generator whenever nothing is playing.
  localparam int unsigned DEF_IDLE_CODE = 100_000_000;
  // Clock cycles per beat: 0.125 s at 100 MHz.
  localparam int unsigned DEF_TICK_DIV  = 12_500_000;

endpackage

// File: rtl/note_sequencer_ram.sv
// Note storage: one write port, one synchronous read port, no reset, so it
// maps onto a block RAM. Contents survive reset; the sequencer's length
// register decides what is reachable.
module note_ram #(
  parameter int FREQ_W = 32,
  parameter int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [FREQ_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [FREQ_W-1:0] o_rd_data
);

  logic [FREQ_W-1:0] r_mem [DEPTH];
  logic [FREQ_W-1:0] r_rd_data;

  // Write port and registered read port on the same clock.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/note_sequencer.sv
// Beat-based note recorder/player. Records note_in once per beat into
// note_ram, trims trailing rests from the take, and plays the take back
// once or in a loop.
//
// state   | meaning
// IDLE    | not recording or playing, note_out = IDLE_CODE
// REC     | writing one note per beat tick
// PLAY    | presenting one stored note per beat tick
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int          FREQ_W    = 32,
  parameter int          DEPTH     = 1024,
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned REST_CODE = DEF_REST_CODE,
  parameter int unsigned IDLE_CODE = DEF_IDLE_CODE,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FREQ_W-1:0] note_in,
  input  logic              rec_start,
  input  logic              rec_stop,
  input  logic              play_start,
  input  logic              play_stop,
  input  logic              loop_en,
  output logic [FREQ_W-1:0] note_out,
  output logic              recording,
  output logic              playing,
  output logic              full,
  output logic [ADDR_W:0]   length
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] SLOT_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [FREQ_W-1:0] REST_V = FREQ_W'(REST_CODE);
  localparam logic [FREQ_W-1:0] IDLE_V = FREQ_W'(IDLE_CODE);

  seq_state_e r_state;
  seq_state_e w_state_nxt;

  logic [CNT_W-1:0]  r_tick_cnt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_last_idx;
  logic [ADDR_W:0]   r_length;
  logic              r_full;
  logic              r_play_done;
  logic [FREQ_W-1:0] r_note_out;

  logic              w_tick;
  logic              w_enter_rec;
  logic              w_enter_play;
  logic              w_rec_wr;
  logic              w_rec_exit;
  logic              w_full_hit;
  logic              w_play_adv;
  logic              w_at_last;
  logic              w_note_sounded;
  logic [ADDR_W:0]   w_last_idx_new;
  logic [FREQ_W-1:0] w_rd_data;

  assign w_tick         = (r_tick_cnt == CNT_LAST);
  assign w_note_sounded = (note_in != REST_V);
  // rd_ptr == length-1, evaluated in the wider length domain.
  assign w_at_last      = ({1'b0, r_rd_ptr} == (r_length - (ADDR_W+1)'(1)));
  // Take length including the write happening this cycle, if any.
  assign w_last_idx_new = (w_rec_wr && w_note_sounded) ?
                          ({1'b0, r_wr_ptr} + (ADDR_W+1)'(1)) : r_last_idx;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_enter_rec  = 1'b0;
    w_enter_play = 1'b0;
    w_rec_wr     = 1'b0;
    w_rec_exit   = 1'b0;
    w_full_hit   = 1'b0;
    w_play_adv   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // rec_start wins over a coincident play_start.
        if (rec_start) begin
          w_enter_rec = 1'b1;
          w_state_nxt = ST_REC;
        end else if (play_start && (r_length != '0)) begin
          w_enter_play = 1'b1;
          w_state_nxt  = ST_PLAY;
        end
      end
      ST_REC: begin
        // A tick's write completes even when rec_stop arrives on it.
        if (w_tick) begin
          w_rec_wr   = 1'b1;
          w_full_hit = (r_wr_ptr == SLOT_LAST);
        end
        if (rec_stop || w_full_hit) begin
          w_rec_exit  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (play_stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          if (r_play_done) w_state_nxt = ST_IDLE;
          else             w_play_adv  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Beat divider; restarts on entry to REC or PLAY so the first tick lands
  // exactly TICK_DIV cycles after the command.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             r_tick_cnt <= '0;
    else if (w_enter_rec || w_enter_play)  r_tick_cnt <= '0;
    else if (w_tick)                       r_tick_cnt <= '0;
    else                                   r_tick_cnt <= r_tick_cnt + CNT_W'(1);
  end

  // Record-side pointers, take length and full flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_last_idx <= '0;
      r_length   <= '0;
      r_full     <= 1'b0;
    end else begin
      if (w_enter_rec) begin
        r_wr_ptr   <= '0;
        r_last_idx <= '0;
        r_full     <= 1'b0;
      end else begin
        if (w_rec_wr) begin
          r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
          r_last_idx <= w_last_idx_new;
        end
        if (w_full_hit) r_full   <= 1'b1;
        if (w_rec_exit) r_length <= w_last_idx_new;
      end
    end
  end

  // Playback pointer; loop_en is looked at only when the last note is reached.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr    <= '0;
      r_play_done <= 1'b0;
    end else if (w_enter_play) begin
      r_rd_ptr    <= '0;
      r_play_done <= 1'b0;
    end else if (w_play_adv) begin
      if (w_at_last) begin
        if (loop_en) r_rd_ptr    <= '0;
        else         r_play_done <= 1'b1;
      end else begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
    end
  end

  // Output note: RAM data latched on each playback tick, IDLE_CODE otherwise.
  // rd_ptr is stable for at least one cycle before every tick, so the RAM's
  // registered read already holds mem[rd_ptr] when the tick arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         r_note_out <= IDLE_V;
    else if (w_play_adv)               r_note_out <= w_rd_data;
    else if (w_state_nxt != ST_PLAY)   r_note_out <= IDLE_V;
  end

  note_ram #(
    .FREQ_W (FREQ_W),
    .DEPTH  (DEPTH)
  ) u_note_ram (
    .i_clk     (clk),
    .i_wr_en   (w_rec_wr),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (note_in),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign note_out  = r_note_out;
  assign recording = (r_state == ST_REC);
  assign playing   = (r_state == ST_PLAY);
  assign full      = r_full;
  assign length    = r_length;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer with a small take model: stored notes, trimmed
// length and full flag, and a beat-by-beat playback expectation.
module tb_note_sequencer;

  localparam int TDIV  = 4;
  localparam int DEP   = 8;
  localparam int REST  = 0;
  localparam int IDLEC = 99;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] note_in;
  logic        rec_start, rec_stop, play_start, play_stop, loop_en;
  logic [31:0] note_out;
  logic        recording, playing, full;
  logic [3:0]  length;

  int n_vec = 0;
  int n_err = 0;

  int unsigned mdl_mem [DEP];
  int          mdl_len  = 0;
  bit          mdl_full = 1'b0;
  int unsigned rec_notes[$];

  note_sequencer #(
    .FREQ_W    (32),
    .DEPTH     (DEP),
    .TICK_DIV  (TDIV),
    .REST_CODE (REST),
    .IDLE_CODE (IDLEC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .note_in    (note_in),
    .rec_start  (rec_start),
    .rec_stop   (rec_stop),
    .play_start (play_start),
    .play_stop  (play_stop),
    .loop_en    (loop_en),
    .note_out   (note_out),
    .recording  (recording),
    .playing    (playing),
    .full       (full),
    .length     (length)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  // Drives a one-cycle command; returns at the negedge after it was sampled.
  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0: rec_start  = 1'b1;
      1: rec_stop   = 1'b1;
      2: play_start = 1'b1;
      default: play_stop = 1'b1;
    endcase
    @(negedge clk);
    rec_start = 1'b0; rec_stop = 1'b0; play_start = 1'b0; play_stop = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    n_vec++;
    if (note_out !== 32'(IDLEC) || playing !== 1'b0 || recording !== 1'b0) begin
      n_err++;
      $display("FAIL %s: note_out=%0d playing=%b recording=%b, required note_out=%0d playing=0 recording=0",
               tag, note_out, playing, recording, IDLEC);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; note_in = '0; loop_en = 1'b0;
    rec_start = 1'b0; rec_stop = 1'b0; play_start = 1'b0; play_stop = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_outputs");
    n_vec++;
    if (length !== 4'd0 || full !== 1'b0) begin
      n_err++;
      $display("FAIL reset_len_full: length=%0d full=%b, required 0/0", length, full);
    end
    @(negedge clk);
    reset = 1'b0;
    mdl_len = 0; mdl_full = 1'b0;
  endtask

  // Records rec_notes (at most DEPTH entries), one per beat, then updates
  // the model and checks the resulting length/full/recording.
  task automatic record_take(input bit stop_on_tick, input bit poke_play);
    int n;
    int len;
    n = rec_notes.size();
    pulse(0);
    n_vec++;
    if (recording !== 1'b1 || full !== 1'b0) begin
      n_err++;
      $display("FAIL rec_enter: recording=%b full=%b, required 1/0", recording, full);
    end
    for (int k = 0; k < n; k++) begin
      note_in = rec_notes[k];
      for (int s = 0; s < 3; s++) begin
        @(negedge clk);
        play_start = (poke_play && k == 0 && s == 0);
      end
      if (k == n - 1 && stop_on_tick) rec_stop = 1'b1;
      @(negedge clk);
      rec_stop = 1'b0;
      if (poke_play && k == 0) begin
        n_vec++;
        if (playing !== 1'b0 || (recording !== 1'b1 && n > 1)) begin
          n_err++;
          $display("FAIL play_in_rec: playing=%b recording=%b, required 0/1", playing, recording);
        end
      end
    end
    if (!(stop_on_tick && n > 0) && n < DEP) pulse(1);
    @(negedge clk);
    len = 0;
    for (int k = 0; k < n; k++) begin
      mdl_mem[k] = rec_notes[k];
      if (rec_notes[k] != REST) len = k + 1;
    end
    mdl_len  = len;
    mdl_full = (n == DEP);
    n_vec++;
    if (recording !== 1'b0 || length !== 4'(mdl_len) || full !== mdl_full) begin
      n_err++;
      $display("FAIL rec_result: recording=%b length=%0d full=%b, required 0/%0d/%b",
               recording, length, full, mdl_len, mdl_full);
    end
  endtask

  // mode: 0 play once, 1 loop, 2 loop_en randomised every cycle.
  // stop_beat > 0 asserts play_stop on the cycle of that beat's tick.
  task automatic play_take(input int mode, input int stop_beat, input int max_beats);
    int unsigned cur;
    bit exp_play, ending;
    int idx, j;
    loop_en = (mode != 0);
    if (mdl_len == 0) begin
      pulse(2);
      repeat (2) @(negedge clk);
      check_idle_outputs("play_empty_ignored");
      return;
    end
    pulse(2);
    cur = IDLEC; exp_play = 1'b1; ending = 1'b0; idx = 0; j = 0;
    n_vec++;
    if (playing !== 1'b1 || note_out !== 32'(IDLEC)) begin
      n_err++;
      $display("FAIL play_enter: playing=%b note_out=%0d, required 1/%0d", playing, note_out, IDLEC);
    end
    while (exp_play && j < max_beats * TDIV) begin
      @(negedge clk);
      j++;
      if (play_stop) begin
        cur = IDLEC; exp_play = 1'b0;
        play_stop = 1'b0;
      end else if (j % TDIV == 0) begin
        if (ending) begin
          cur = IDLEC; exp_play = 1'b0;
        end else begin
          cur = mdl_mem[idx];
          if (idx == mdl_len - 1) begin
            if (loop_en) idx = 0;
            else         ending = 1'b1;
          end else begin
            idx++;
          end
        end
      end
      n_vec++;
      if (note_out !== 32'(cur) || playing !== exp_play) begin
        n_err++;
        $display("FAIL play_cycle%0d: note_out=%0d playing=%b, required %0d/%b",
                 j, note_out, playing, cur, exp_play);
      end
      if (mode == 2) loop_en = 1'($urandom_range(0, 1));
      if (stop_beat > 0 && j == stop_beat * TDIV - 1) play_stop = 1'b1;
    end
    play_stop = 1'b0;
    if (exp_play) begin
      pulse(3);
      check_idle_outputs("play_stop_after_budget");
    end
    loop_en = 1'b0;
  endtask

  task automatic test_basic_record();
    rec_notes = '{5, 6, 7};
    record_take(1'b0, 1'b1);
  endtask

  task automatic test_play_once();
    play_take(0, 0, 10);
  endtask

  task automatic test_trim();
    rec_notes = '{5, 0, 0};
    record_take(1'b0, 1'b0);
    play_take(0, 0, 10);
    rec_notes = '{0, 0};
    record_take(1'b0, 1'b0);
    play_take(0, 0, 10);
  endtask

  task automatic test_full();
    pulse(0);
    note_in = 9;
    repeat (DEP * TDIV) @(negedge clk);
    n_vec++;
    if (full !== 1'b1 || length !== 4'(DEP) || recording !== 1'b0) begin
      n_err++;
      $display("FAIL full_hit: full=%b length=%0d recording=%b, required 1/%0d/0",
               full, length, recording, DEP);
    end
    repeat (2 * TDIV) @(negedge clk);
    pulse(1);
    for (int k = 0; k < DEP; k++) mdl_mem[k] = 9;
    mdl_len = DEP; mdl_full = 1'b1;
    n_vec++;
    if (full !== 1'b1 || length !== 4'(DEP) || recording !== 1'b0) begin
      n_err++;
      $display("FAIL full_stop_ignored: full=%b length=%0d recording=%b, required 1/%0d/0",
               full, length, recording, DEP);
    end
    play_take(0, 0, DEP + 3);
  endtask

  task automatic test_loop();
    rec_notes = '{5, 6, 7};
    record_take(1'b0, 1'b0);
    play_take(1, 7, 20);
    play_take(1, 0, 8);
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(0, DEP);
      rec_notes.delete();
      for (int k = 0; k < n; k++)
        rec_notes.push_back(($urandom_range(0, 9) < 3) ? REST : $urandom_range(1, 1000));
      record_take(1'($urandom_range(0, 1)), 1'b0);
      play_take($urandom_range(0, 1) * 2, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0, 24);
    end
  endtask

  task automatic test_reset_mid_play();
    rec_notes = '{5, 6, 7};
    record_take(1'b0, 1'b0);
    pulse(2);
    repeat (6) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("reset_mid_play");
    n_vec++;
    if (length !== 4'd0) begin
      n_err++;
      $display("FAIL reset_mid_play_len: length=%0d, required 0", length);
    end
    @(negedge clk);
    reset = 1'b0;
    mdl_len = 0; mdl_full = 1'b0;
    play_take(0, 0, 4);
  endtask

  initial begin
    test_reset();
    test_basic_record();
    test_play_once();
    test_trim();
    test_full();
    test_loop();
    test_random();
    test_reset_mid_play();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
